// File: rtl/gui_field_overlay.sv
// LCD overlay: waveform window, cyan border and NUM_FIELDS labelled BCD readouts latched once per frame.
// Optional macro GUI_GRID_EN adds a dark-grey graticule to the waveform window background.
module gui_field_overlay #(
  parameter int NUM_FIELDS   = 2,
  parameter int DIGITS       = 3,
  parameter int ROM_LAT      = 1,
  parameter int WAVE_W       = 500,
  parameter int WAVE_H       = 256,
  parameter int FIELD_X0     = 20,
  parameter int FIELD_Y0     = 340,
  parameter int FIELD_PITCH  = 50,
  parameter int LABEL_W      = 80,
  parameter int LABEL_BASE   = 11,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                           lcd_pclk,
  input  logic                           rst_n,
  input  logic [10:0]                    pixel_xpos,
  input  logic [10:0]                    pixel_ypos,
  input  logic                           wavepoint,
  input  logic [NUM_FIELDS*DIGITS*4-1:0] field_bcd,
  input  logic [NUM_FIELDS-1:0]          field_valid,
  input  logic [NUM_FIELDS-1:0]          field_alarm,
  output logic [10:0]                    char_x,
  output logic [10:0]                    char_y,
  output logic [6:0]                     char_n,
  input  logic                           char_p,
  output logic [23:0]                    pixel_data,
  output logic                           frame_tick
);

  localparam int          FW    = NUM_FIELDS*DIGITS*4;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] CYAN  = 24'h00FFFF;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] GREY  = 24'h404040;
  localparam logic [6:0]  DASH  = 7'd21;
  localparam logic [6:0]  BLANK = 7'd127;

  logic [FW-1:0]         sh_bcd;
  logic [NUM_FIELDS-1:0] sh_valid;
  logic [NUM_FIELDS-1:0] sh_alarm;
  logic                  origin;
  logic                  origin_d;
  logic                  load;
  logic [15:0]           blink_cnt;
  logic                  blink_hidden;
  logic                  grid;

  logic                  d_glyph;
  logic [23:0]           d_fg;
  logic [23:0]           d_bg;
  logic [6:0]            d_n;
  logic [10:0]           d_cx;
  logic [10:0]           d_cy;

  logic                  glyph_pipe [ROM_LAT+1];
  logic [23:0]           fg_pipe    [ROM_LAT+1];
  logic [23:0]           bg_pipe    [ROM_LAT+1];

  // Only the first cycle at the origin loads, so a driver parked at (0,0) still ticks once.
  assign origin = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
  assign load   = origin && !origin_d;

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      origin_d     <= 1'b0;
      frame_tick   <= 1'b0;
      sh_bcd       <= '0;
      sh_valid     <= '0;
      sh_alarm     <= '0;
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
    end else begin
      origin_d   <= origin;
      frame_tick <= load;
      if (load) begin
        sh_bcd   <= field_bcd;
        sh_valid <= field_valid;
        sh_alarm <= field_alarm;
      end
      if (frame_tick) begin
        if (blink_cnt == 16'(BLINK_FRAMES-1)) begin
          blink_cnt    <= '0;
          blink_hidden <= !blink_hidden;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end

`ifdef GUI_GRID_EN
  logic [5:0]  gx_q, gx_now;
  logic [4:0]  gy_q, gy_now;
  logic [10:0] last_x, last_y;

  // Modulo counters follow the raster: restart at 0 and advance whenever the coordinate moves on.
  always_comb begin
    gx_now = gx_q;
    gy_now = gy_q;
    if (pixel_xpos == 11'd0)       gx_now = '0;
    else if (pixel_xpos != last_x) gx_now = (gx_q == 6'd49) ? 6'd0 : gx_q + 6'd1;
    if (pixel_ypos == 11'd0)       gy_now = '0;
    else if (pixel_ypos != last_y) gy_now = gy_q + 5'd1;
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      gx_q   <= '0;
      gy_q   <= '0;
      last_x <= '0;
      last_y <= '0;
    end else begin
      gx_q   <= gx_now;
      gy_q   <= gy_now;
      last_x <= pixel_xpos;
      last_y <= pixel_ypos;
    end
  end

  assign grid = (gx_now == 6'd0) || (gy_now == 5'd0);
`else
  assign grid = 1'b0;
`endif

  // Fields are scanned from the highest index down so the lowest overlapping field wins.
  always_comb begin
    int         x;
    int         y;
    int         fy;
    int         dx0;
    logic       hit;
    logic       lead;
    logic [3:0] nib;
    x       = int'(pixel_xpos);
    y       = int'(pixel_ypos);
    fy      = 0;
    dx0     = 0;
    hit     = 1'b0;
    lead    = 1'b1;
    nib     = 4'd0;
    d_glyph = 1'b0;
    d_fg    = BLACK;
    d_bg    = BLACK;
    d_n     = BLANK;
    d_cx    = '0;
    d_cy    = '0;
    if (x < WAVE_W && y < WAVE_H) begin
      d_bg = wavepoint ? GREEN : (grid ? GREY : BLACK);
    end else begin
      for (int k = NUM_FIELDS-1; k >= 0; k--) begin
        fy = FIELD_Y0 + k*FIELD_PITCH;
        if (y >= fy && y < fy + 32) begin
          if (x >= FIELD_X0 && x < FIELD_X0 + LABEL_W) begin
            hit     = 1'b1;
            d_glyph = 1'b1;
            d_n     = 7'(LABEL_BASE + k);
            d_cx    = 11'(x - FIELD_X0);
            d_cy    = 11'(y - fy);
            d_fg    = WHITE;
            d_bg    = BLACK;
          end
          lead = 1'b1;
          for (int j = 0; j < DIGITS; j++) begin
            nib = sh_bcd[k*DIGITS*4 + (DIGITS-1-j)*4 +: 4];
            dx0 = FIELD_X0 + LABEL_W + 16*j;
            if (x >= dx0 && x < dx0 + 16) begin
              hit  = 1'b1;
              d_cx = 11'(x - dx0);
              d_cy = 11'(y - fy);
              if (!sh_valid[k] || nib > 4'd9)                d_n = DASH;
              else if (lead && nib == 4'd0 && j < DIGITS-1) d_n = BLANK;
              else                                          d_n = 7'(nib);
              d_glyph = (d_n != BLANK);
              d_fg    = sh_alarm[k] ? (blink_hidden ? BLACK : RED) : CYAN;
              d_bg    = BLACK;
            end
            lead = lead && (nib == 4'd0);
          end
        end
      end
      if (!hit && (x == WAVE_W || y == WAVE_H)) d_bg = CYAN;
    end
  end

  // Stage 1 drives the glyph ROM; the colour tag then waits ROM_LAT cycles for char_p.
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      char_x     <= '0;
      char_y     <= '0;
      char_n     <= BLANK;
      pixel_data <= BLACK;
      for (int i = 0; i <= ROM_LAT; i++) begin
        glyph_pipe[i] <= 1'b0;
        fg_pipe[i]    <= BLACK;
        bg_pipe[i]    <= BLACK;
      end
    end else begin
      char_x        <= d_cx;
      char_y        <= d_cy;
      char_n        <= d_n;
      glyph_pipe[0] <= d_glyph;
      fg_pipe[0]    <= d_fg;
      bg_pipe[0]    <= d_bg;
      for (int i = 1; i <= ROM_LAT; i++) begin
        glyph_pipe[i] <= glyph_pipe[i-1];
        fg_pipe[i]    <= fg_pipe[i-1];
        bg_pipe[i]    <= bg_pipe[i-1];
      end
      pixel_data <= (glyph_pipe[ROM_LAT] && char_p) ? fg_pipe[ROM_LAT] : bg_pipe[ROM_LAT];
    end
  end

endmodule
